// File: rtl/sram_test_pkg.sv
// Shared definitions for the SRAM test sequencer: state encoding, pattern
// selections, default bus widths and the LFSR seed/taps.
package sram_test_pkg;

    localparam int ADDR_WIDTH_DEF = 19;
    localparam int DATA_WIDTH_DEF = 8;

    typedef logic [2:0] state_t;
    localparam state_t ST_SETTLE   = 3'd0;
    localparam state_t ST_IDLE     = 3'd1;
    localparam state_t ST_WR_ISSUE = 3'd2;
    localparam state_t ST_WR_WAIT  = 3'd3;
    localparam state_t ST_RD_ISSUE = 3'd4;
    localparam state_t ST_RD_WAIT  = 3'd5;
    localparam state_t ST_RD_CHECK = 3'd6;
    localparam state_t ST_FINISH   = 3'd7;

    localparam logic [1:0] PAT_ADDR     = 2'd0;
    localparam logic [1:0] PAT_ADDR_INV = 2'd1;
    localparam logic [1:0] PAT_CHECKER  = 2'd2;
    localparam logic [1:0] PAT_ALT      = 2'd3;

    // x^8+x^6+x^5+x^4+1 -> feedback from bits 7,5,4,3
    localparam logic [7:0] LFSR_SEED = 8'h01;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/sram_pattern_gen.sv
// Pattern byte generator. With SRAM_SEQ_LFSR_PATTERN_EN defined, pattern_sel=3
// is an 8-bit Fibonacci LFSR; otherwise it is constant 0x00.
module sram_pattern_gen
    import sram_test_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] addr_i,
    input  logic [1:0] sel_i,
    input  logic       restart_i,
    input  logic       advance_i,
    output logic [7:0] pattern_o
);

    logic [7:0] alt_pattern;

`ifdef SRAM_SEQ_LFSR_PATTERN_EN
    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (restart_i) begin
            lfsr_d = LFSR_SEED;
        end else if (advance_i) begin
            lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign alt_pattern = lfsr_q;
`else
    logic unused_lfsr_inputs;
    assign unused_lfsr_inputs = ^{clk, reset, restart_i, advance_i};
    assign alt_pattern = 8'h00;
`endif

    // NOTE: the default arm gives pattern_o a value on every path, so no latch is inferred.
    always_comb begin
        case (sel_i)
            PAT_ADDR:     pattern_o = addr_i;
            PAT_ADDR_INV: pattern_o = ~addr_i;
            PAT_CHECKER:  pattern_o = addr_i[0] ? 8'hAA : 8'h55;
            default:      pattern_o = alt_pattern;
        endcase
    end

endmodule

// File: rtl/sram_test_sequencer.sv
// Write / read-back / compare sequencer driving the byte-wide SRAM controller.
// Optional feature macro: SRAM_SEQ_LFSR_PATTERN_EN (LFSR pattern on pattern_sel=3).
module sram_test_sequencer
    import sram_test_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LAST_ADDR  = 2**19 - 1,
    parameter int OP_CYCLES  = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            pattern_sel,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           error_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic                  start_operation,
    output logic                  rw,
    output logic [ADDR_WIDTH-1:0] address_input,
    output logic [DATA_WIDTH-1:0] data_f2s,
    input  logic [DATA_WIDTH-1:0] data_s2f
);

    localparam int                    CNT_W     = $clog2(OP_CYCLES);
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(OP_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(LAST_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] first_q, first_d;
    logic [1:0]            sel_q, sel_d;
    logic                  done_q, done_d;
    logic [15:0]           err_q, err_d;

    logic                  pat_restart, pat_advance;
    logic [7:0]            pat_byte;
    logic [DATA_WIDTH-1:0] pattern;
    logic                  in_write, at_last, cnt_done;

    sram_pattern_gen u_pattern_gen (
        .clk       (clk),
        .reset     (reset),
        .addr_i    (addr_q[7:0]),
        .sel_i     (sel_q),
        .restart_i (pat_restart),
        .advance_i (pat_advance),
        .pattern_o (pat_byte)
    );

    assign pattern  = DATA_WIDTH'(pat_byte);
    assign at_last  = (addr_q == ADDR_LAST);
    assign cnt_done = (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        first_d     = first_q;
        sel_d       = sel_q;
        done_d      = done_q;
        err_d       = err_q;
        pat_restart = 1'b0;
        pat_advance = 1'b0;

        case (state_q)
            ST_SETTLE: begin
                if (cnt_done) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_IDLE: begin
                if (start) begin
                    sel_d       = pattern_sel;
                    done_d      = 1'b0;
                    err_d       = '0;
                    first_d     = '0;
                    addr_d      = '0;
                    pat_restart = 1'b1;
                    state_d     = ST_WR_ISSUE;
                end
            end
            ST_WR_ISSUE: begin
                cnt_d   = CNT_ONE;
                state_d = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (!cnt_done) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else if (at_last) begin
                    addr_d      = '0;
                    pat_restart = 1'b1;
                    state_d     = ST_RD_ISSUE;
                end else begin
                    addr_d      = addr_q + ADDR_ONE;
                    pat_advance = 1'b1;
                    state_d     = ST_WR_ISSUE;
                end
            end
            ST_RD_ISSUE: begin
                cnt_d   = CNT_ONE;
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (cnt_done) begin
                    state_d = ST_RD_CHECK;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RD_CHECK: begin
                if (data_s2f != pattern) begin
                    if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                    // err_q never returns to zero within a run, so this marks the first miss
                    if (err_q == '0) first_d = addr_q;
                end
                if (at_last) begin
                    done_d  = 1'b1;
                    state_d = ST_FINISH;
                end else begin
                    addr_d      = addr_q + ADDR_ONE;
                    pat_advance = 1'b1;
                    state_d     = ST_RD_ISSUE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: non-blocking updates let every register sample the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_SETTLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            first_q <= '0;
            sel_q   <= PAT_ADDR;
            done_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            first_q <= first_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign in_write        = (state_q == ST_WR_ISSUE) || (state_q == ST_WR_WAIT);
    assign start_operation = (state_q == ST_WR_ISSUE) || (state_q == ST_RD_ISSUE);
    assign rw              = ~in_write;
    assign address_input   = addr_q;
    assign data_f2s        = in_write ? pattern : '0;
    assign busy            = (state_q != ST_IDLE) && (state_q != ST_FINISH);
    assign done            = done_q;
    assign pass            = done_q && (err_q == '0);
    assign error_count     = err_q;
    assign first_err_addr  = first_q;

endmodule

// File: tb/tb_sram_test_sequencer.sv
// Self-checking bench for sram_test_sequencer: LAST_ADDR=15, behavioural SRAM and
// controller model with fault injection, randomized runs against a pattern model.
module tb_sram_test_sequencer;

    localparam int AW         = 19;
    localparam int DW         = 8;
    localparam int LAST       = 15;
    localparam int OPC        = 6;
    localparam int RD_LAT     = 3;
    localparam int RUN_CYCLES = (LAST + 1) * OPC + (LAST + 1) * (OPC + 1) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    pattern_sel;
    logic          busy, done, pass, start_operation, rw;
    logic [15:0]   error_count;
    logic [AW-1:0] first_err_addr, address_input;
    logic [DW-1:0] data_f2s;
    logic [DW-1:0] data_s2f = '0;

    // fault injection applied on the read path of the model
    bit         force_en;
    logic [3:0] force_addr;
    logic [7:0] force_val, stuck_or, stuck_and;

    logic [7:0] mem [16];
    int         sop_total = 0, wr_total = 0, rd_total = 0, consec_total = 0, hold_total = 0;
    logic       sop_prev = 1'b0;
    int         rd_wait = 0;
    logic [3:0] rd_addr = '0;

    int n_cmp = 0;
    int n_err = 0;

    sram_test_sequencer #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LAST_ADDR  (LAST),
        .OP_CYCLES  (OPC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .pattern_sel     (pattern_sel),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .error_count     (error_count),
        .first_err_addr  (first_err_addr),
        .start_operation (start_operation),
        .rw              (rw),
        .address_input   (address_input),
        .data_f2s        (data_f2s),
        .data_s2f        (data_s2f)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] fault_view(input logic [3:0] a, input logic [7:0] v);
        logic [7:0] r;
        r = (v | stuck_or) & stuck_and;
        if (force_en && a == force_addr) r = force_val;
        return r;
    endfunction

    function automatic logic [7:0] exp_pat(input logic [1:0] sel, input int a);
        logic [7:0] v;
        case (sel)
            2'd0:    v = 8'(a);
            2'd1:    v = ~8'(a);
            2'd2:    v = (a % 2 == 0) ? 8'h55 : 8'hAA;
            default: begin
`ifdef SRAM_SEQ_LFSR_PATTERN_EN
                v = 8'h01;
                for (int i = 0; i < a; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
`else
                v = 8'h00;
`endif
            end
        endcase
        return v;
    endfunction

    // SRAM + controller model: writes land at once, reads return after RD_LAT cycles
    always @(posedge clk) begin
        if (rd_wait > 0) begin
            if (rw !== 1'b1 || address_input[3:0] !== rd_addr) hold_total <= hold_total + 1;
            if (rd_wait == 1) data_s2f <= fault_view(rd_addr, mem[rd_addr]);
            rd_wait <= rd_wait - 1;
        end
        if (start_operation === 1'b1) begin
            sop_total <= sop_total + 1;
            if (sop_prev) consec_total <= consec_total + 1;
            if (rw === 1'b0) begin
                mem[address_input[3:0]] <= data_f2s;
                wr_total <= wr_total + 1;
            end else begin
                rd_total <= rd_total + 1;
                rd_wait  <= RD_LAT;
                rd_addr  <= address_input[3:0];
            end
        end
        sop_prev <= (start_operation === 1'b1);
    end

    task automatic clear_faults();
        force_en   = 1'b0;
        force_addr = '0;
        force_val  = '0;
        stuck_or   = 8'h00;
        stuck_and  = 8'hFF;
    endtask

    task automatic run_and_check(input logic [1:0] sel, input bit poke, input string tag);
        int         cyc, exp_errs, exp_first, bad, sop0, wr0, rd0, con0, hold0;
        bit         busy_ok;
        logic [7:0] w;
        exp_errs = 0;
        exp_first = 0;
        for (int a = 0; a <= LAST; a++) begin
            w = exp_pat(sel, a);
            if (fault_view(4'(a), w) !== w) begin
                if (exp_errs == 0) exp_first = a;
                exp_errs++;
            end
        end
        sop0 = sop_total; wr0 = wr_total; rd0 = rd_total; con0 = consec_total; hold0 = hold_total;

        pattern_sel = sel;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pattern_sel = 2'($urandom);
        cyc = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && cyc < 3 * RUN_CYCLES) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            cyc++;
            start = poke && (cyc == 40 || cyc == 150);
            @(negedge clk);
        end
        start = 1'b0;

        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL %s_timeout: done=%b after %0d cycles", tag, done, cyc); end
        n_cmp++; if (cyc + 1 != RUN_CYCLES) begin n_err++; $display("FAIL %s_run_length: got %0d want %0d", tag, cyc + 1, RUN_CYCLES); end
        n_cmp++; if (!busy_ok || busy !== 1'b0) begin n_err++; $display("FAIL %s_busy: busy_ok=%b busy_at_done=%b want 1/0", tag, busy_ok, busy); end
        n_cmp++; if (error_count !== 16'(exp_errs)) begin n_err++; $display("FAIL %s_error_count: got %0d want %0d", tag, error_count, exp_errs); end
        n_cmp++; if (first_err_addr !== AW'(exp_first)) begin n_err++; $display("FAIL %s_first_err_addr: got %0d want %0d", tag, first_err_addr, exp_first); end
        n_cmp++; if (pass !== (exp_errs == 0)) begin n_err++; $display("FAIL %s_pass: got %b want %b", tag, pass, exp_errs == 0); end
        n_cmp++; if (sop_total - sop0 != 2 * (LAST + 1)) begin n_err++; $display("FAIL %s_start_ops: got %0d want %0d", tag, sop_total - sop0, 2 * (LAST + 1)); end
        n_cmp++; if (wr_total - wr0 != LAST + 1 || rd_total - rd0 != LAST + 1) begin n_err++; $display("FAIL %s_op_mix: writes %0d reads %0d want %0d each", tag, wr_total - wr0, rd_total - rd0, LAST + 1); end
        n_cmp++; if (consec_total != con0 || hold_total != hold0) begin n_err++; $display("FAIL %s_protocol: back-to-back %0d, unstable read cycles %0d, want 0/0", tag, consec_total - con0, hold_total - hold0); end
        bad = 0;
        for (int a = 0; a <= LAST; a++) if (mem[a] !== exp_pat(sel, a)) bad++;
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL %s_write_data: %0d addresses wrong, want 0", tag, bad); end

        @(negedge clk);
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL %s_done_sticky: done=%b busy=%b want 1/0", tag, done, busy); end
    endtask

    task automatic settle_check(input string tag);
        int cyc, sop0;
        sop0 = sop_total;
        cyc = 0;
        while (busy === 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            start = (cyc == 1 || cyc == 3);
        end
        start = 1'b0;
        n_cmp++; if (cyc != OPC) begin n_err++; $display("FAIL %s_settle_len: got %0d want %0d", tag, cyc, OPC); end
        repeat (4) @(negedge clk);
        n_cmp++; if (sop_total != sop0 || busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL %s_settle_ignore: start_ops %0d busy %b done %b want 0/0/0", tag, sop_total - sop0, busy, done); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if ({busy, done, pass, start_operation, rw} !== 5'b10001) begin n_err++; $display("FAIL reset_flags: busy,done,pass,sop,rw got %b want 10001", {busy, done, pass, start_operation, rw}); end
        n_cmp++; if (address_input !== '0 || data_f2s !== '0) begin n_err++; $display("FAIL reset_bus: addr %0h data %0h want 0/0", address_input, data_f2s); end
        n_cmp++; if (error_count !== '0 || first_err_addr !== '0) begin n_err++; $display("FAIL reset_status: err %0d first %0d want 0/0", error_count, first_err_addr); end
        start = 1'b1;   // coincident with reset release
        reset = 1'b0;
        settle_check("reset");
    endtask

    task automatic test_address_pattern();
        clear_faults();
        run_and_check(2'd0, 1'b0, "addr");
    endtask

    task automatic test_forced_error();
        clear_faults();
        force_en   = 1'b1;
        force_addr = 4'd5;
        force_val  = 8'h00;
        run_and_check(2'd2, 1'b0, "forced5");
        clear_faults();
    endtask

    task automatic test_stuck_bit();
        clear_faults();
        stuck_or = 8'h01;
        run_and_check(2'd1, 1'b0, "stuck_inv");
        run_and_check(2'd0, 1'b0, "stuck_addr");
        clear_faults();
    endtask

    task automatic test_start_while_busy();
        clear_faults();
        run_and_check(2'd2, 1'b1, "busy_start");
    endtask

    task automatic test_reset_mid_write();
        int cyc;
        bit found;
        clear_faults();
        pattern_sel = 2'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        cyc = 0;
        while (!found && cyc < RUN_CYCLES) begin
            if (start_operation === 1'b1 && rw === 1'b0 && address_input === AW'(7)) found = 1'b1;
            else begin @(negedge clk); cyc++; end
        end
        n_cmp++; if (!found) begin n_err++; $display("FAIL midreset_reach: write to address 7 not seen in %0d cycles", cyc); end
        reset = 1'b1;
        #1;
        n_cmp++; if ({start_operation, busy, rw, done} !== 4'b0110) begin n_err++; $display("FAIL midreset_outputs: sop,busy,rw,done got %b want 0110", {start_operation, busy, rw, done}); end
        n_cmp++; if (address_input !== '0 || data_f2s !== '0 || error_count !== '0) begin n_err++; $display("FAIL midreset_bus: addr %0h data %0h err %0d want 0", address_input, data_f2s, error_count); end
        @(negedge clk);
        reset = 1'b0;
        settle_check("midreset");
        run_and_check(2'd0, 1'b0, "after_reset");
    endtask

    task automatic test_alt_pattern();
        logic [7:0] exp2;
        clear_faults();
        run_and_check(2'd3, 1'b0, "alt");
`ifdef SRAM_SEQ_LFSR_PATTERN_EN
        exp2 = 8'h04;
`else
        exp2 = 8'h00;
`endif
        n_cmp++; if (mem[2] !== exp2) begin n_err++; $display("FAIL alt_addr2: got %h want %h", mem[2], exp2); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 5; it++) begin
            force_en   = ($urandom_range(0, 1) == 1);
            force_addr = 4'($urandom);
            force_val  = 8'($urandom);
            stuck_or   = ($urandom_range(0, 2) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
            stuck_and  = ($urandom_range(0, 2) == 0) ? ~(8'h01 << $urandom_range(0, 7)) : 8'hFF;
            run_and_check(2'($urandom), 1'b0, "random");
        end
        clear_faults();
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        pattern_sel = 2'd0;
        clear_faults();
        test_reset();
        test_address_pattern();
        test_forced_error();
        test_stuck_bit();
        test_start_while_busy();
        test_reset_mid_write();
        test_alt_pattern();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
